// File: rtl/dial_pkg.sv
// Shared types and constants for the dial quadrature generator: channel FSM
// states, the Gray phase table and the idle/reset encodings.
package dial_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MOVE_CW  = 2'd1,
    MOVE_CCW = 2'd2
  } dial_state_e;

  // Phase index 0..3 -> dial bits; neighbouring entries differ in one bit.
  localparam logic [3:0][1:0] GRAY_LUT = {2'b10, 2'b11, 2'b01, 2'b00};

  localparam logic [1:0] RESET_PHASE = 2'd2;
  localparam logic [1:0] DIAL_IDLE   = 2'b11;

  // Cycles between steps at a given speed level, never below one.
  function automatic int unsigned step_period(input int unsigned base,
                                              input int unsigned level);
    int unsigned p;
    p = base >> level;
    return (p == 0) ? 1 : p;
  endfunction

endpackage

// File: rtl/dial_channel.sv
// One player's spinner: input register, stepping FSM, period/level/step
// counters and the registered dial output (Gray phase or legacy pattern).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no direction requested (or legacy mode); phase held
// MOVE_CW  | stepping phase +1 every period, accelerating while held
// MOVE_CCW | stepping phase -1 every period, accelerating while held
module dial_channel
  import dial_pkg::*;
#(
  parameter int unsigned BASE_DIV    = 12000,
  parameter int unsigned ACCEL_STEPS = 64,
  parameter int unsigned MAX_LEVEL   = 3
) (
  input  logic       clk_sys_i,
  input  logic       rst_n_i,
  input  logic       paused_i,
  input  logic       up_i,
  input  logic       down_i,
  input  logic       spin_en_i,
  input  logic       dir_inv_i,
  output logic [1:0] dial_o,
  output logic       step_o
);

  localparam int CNT_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam int LVL_W = (MAX_LEVEL > 0) ? $clog2(MAX_LEVEL + 1) : 1;
  localparam int SC_W  = (ACCEL_STEPS > 1) ? $clog2(ACCEL_STEPS) : 1;

  logic             up_q, down_q, en_q, inv_q;
  dial_state_e      state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [SC_W-1:0]  scnt_q, scnt_d;
  logic             step_q, step_d;
  logic [1:0]       dial_q, dial_d;

  logic cw_raw, ccw_raw, cw, ccw, entering;

  assign cw_raw  = up_q & ~down_q;
  assign ccw_raw = down_q & ~up_q;
  assign cw      = inv_q ? ccw_raw : cw_raw;
  assign ccw     = inv_q ? cw_raw : ccw_raw;

  // Inputs keep sampling during pause so the first unpaused cycle sees fresh requests.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      en_q    <= 1'b0;
      inv_q   <= 1'b0;
      state_q <= IDLE;
      phase_q <= RESET_PHASE;
      cnt_q   <= '0;
      level_q <= '0;
      scnt_q  <= '0;
      step_q  <= 1'b0;
      dial_q  <= DIAL_IDLE;
    end else begin
      up_q    <= up_i;
      down_q  <= down_i;
      en_q    <= spin_en_i;
      inv_q   <= dir_inv_i;
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      scnt_q  <= scnt_d;
      step_q  <= step_d;
      dial_q  <= dial_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!paused_i) begin
      if (!en_q) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (cw)       state_d = MOVE_CW;
            else if (ccw) state_d = MOVE_CCW;
          end
          MOVE_CW: begin
            if (ccw)      state_d = MOVE_CCW;
            else if (!cw) state_d = IDLE;
          end
          MOVE_CCW: begin
            if (cw)        state_d = MOVE_CW;
            else if (!ccw) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // A change into either MOVE state (from IDLE or a reversal) is a fresh entry.
  assign entering = (state_d != state_q) && (state_d != IDLE);

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    scnt_d  = scnt_q;
    step_d  = 1'b0;
    dial_d  = dial_q;
    if (!paused_i) begin
      if (!en_q) begin
        phase_d = RESET_PHASE;
        cnt_d   = '0;
        level_d = '0;
        scnt_d  = '0;
        if (down_q)    dial_d = 2'b01;
        else if (up_q) dial_d = 2'b10;
        else           dial_d = DIAL_IDLE;
      end else begin
        dial_d = GRAY_LUT[phase_q];
        if (state_d == IDLE) begin
          cnt_d   = '0;
          level_d = '0;
          scnt_d  = '0;
        end else if (entering) begin
          step_d  = 1'b1;
          cnt_d   = CNT_W'(BASE_DIV - 1);
          level_d = '0;
          scnt_d  = '0;
        end else if (cnt_q == '0) begin
          step_d = 1'b1;
          if (scnt_q == SC_W'(ACCEL_STEPS - 1)) begin
            scnt_d = '0;
            if (level_q < LVL_W'(MAX_LEVEL)) level_d = level_q + 1'b1;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
          cnt_d = CNT_W'(step_period(BASE_DIV, 32'(level_d)) - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        if (step_d) phase_d = (state_d == MOVE_CW) ? phase_q + 2'd1 : phase_q - 2'd1;
      end
    end
  end

  assign dial_o = dial_q;
  assign step_o = step_q;

endmodule

// File: rtl/dial_quadrature_gen.sv
// Two-player joystick-to-spinner converter: one dial_channel per player,
// outputs mapped onto the core's dial bits and a per-player step strobe.
module dial_quadrature_gen
  import dial_pkg::*;
#(
  parameter int unsigned BASE_DIV    = 12000,
  parameter int unsigned ACCEL_STEPS = 64,
  parameter int unsigned MAX_LEVEL   = 3
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       paused,
  input  logic [1:0] up,
  input  logic [1:0] down,
  input  logic [1:0] spin_en,
  input  logic [1:0] dir_inv,
  output logic [1:0] dial_p1,
  output logic [1:0] dial_p2,
  output logic [1:0] step_pulse
);

  dial_channel #(
    .BASE_DIV   (BASE_DIV),
    .ACCEL_STEPS(ACCEL_STEPS),
    .MAX_LEVEL  (MAX_LEVEL)
  ) u_ch_p1 (
    .clk_sys_i (clk_sys),
    .rst_n_i   (reset_n),
    .paused_i  (paused),
    .up_i      (up[0]),
    .down_i    (down[0]),
    .spin_en_i (spin_en[0]),
    .dir_inv_i (dir_inv[0]),
    .dial_o    (dial_p1),
    .step_o    (step_pulse[0])
  );

  dial_channel #(
    .BASE_DIV   (BASE_DIV),
    .ACCEL_STEPS(ACCEL_STEPS),
    .MAX_LEVEL  (MAX_LEVEL)
  ) u_ch_p2 (
    .clk_sys_i (clk_sys),
    .rst_n_i   (reset_n),
    .paused_i  (paused),
    .up_i      (up[1]),
    .down_i    (down[1]),
    .spin_en_i (spin_en[1]),
    .dir_inv_i (dir_inv[1]),
    .dial_o    (dial_p2),
    .step_o    (step_pulse[1])
  );

endmodule

// File: tb/tb_dial_quadrature_gen.sv
// Directed bench for dial_quadrature_gen with a short period (8) and fast
// acceleration (4 steps per level) so every behaviour fits in a few hundred cycles.
module tb_dial_quadrature_gen;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       paused;
  logic [1:0] up, down, spin_en, dir_inv;
  logic [1:0] dial_p1, dial_p2, step_pulse;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;
  int q1[$];
  int q2[$];
  int n1;
  int exp_gap3[15];
  int exp_gap5[4];

  dial_quadrature_gen #(
    .BASE_DIV   (8),
    .ACCEL_STEPS(4),
    .MAX_LEVEL  (3)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .paused    (paused),
    .up        (up),
    .down      (down),
    .spin_en   (spin_en),
    .dir_inv   (dir_inv),
    .dial_p1   (dial_p1),
    .dial_p2   (dial_p2),
    .step_pulse(step_pulse)
  );

  always #5 clk_sys = ~clk_sys;

  // Strobe log: cycle number of every step_pulse, sampled on the falling edge.
  always @(negedge clk_sys) begin
    cyc <= cyc + 1;
    if (step_pulse[0]) q1.push_back(cyc);
    if (step_pulse[1]) q2.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gap1(input int i);
    return (q1.size() > i + 1) ? q1[i+1] - q1[i] : -1;
  endfunction

  function automatic int gap2(input int i);
    return (q2.size() > i + 1) ? q2[i+1] - q2[i] : -1;
  endfunction

  initial begin
    exp_gap3 = '{8, 8, 8, 8, 4, 4, 4, 4, 2, 2, 2, 2, 1, 1, 1};
    exp_gap5 = '{8, 8, 3, 8};
    reset_n = 1'b0; paused = 1'b0;
    up = 2'b00; down = 2'b00; spin_en = 2'b00; dir_inv = 2'b00;

    // Reset values
    #12;
    check("rst_dial_p1", int'(dial_p1), 3);
    check("rst_dial_p2", int'(dial_p2), 3);
    check("rst_step", int'(step_pulse), 0);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    tick(2);

    // Legacy mode, two-cycle registered pass-through, dir_inv ignored
    dir_inv = 2'b01;
    down = 2'b01;             tick(2); check("leg_down", int'(dial_p1), 1);
    up = 2'b01; down = 2'b00; tick(2); check("leg_up", int'(dial_p1), 2);
    up = 2'b01; down = 2'b01; tick(2); check("leg_both", int'(dial_p1), 1);
    up = 2'b00; down = 2'b00; tick(2); check("leg_rel", int'(dial_p1), 3);
    check("leg_p2_idle", int'(dial_p2), 3);
    check("leg_no_strobe", q1.size() + q2.size(), 0);

    // P1 clockwise at base rate
    dir_inv = 2'b00; spin_en = 2'b01;
    tick(3);
    check("cw_en_dial", int'(dial_p1), 3);
    q1.delete();
    up = 2'b01;
    tick(2); check("cw_first_strobe", int'(step_pulse), 1);
             check("cw_lat_hold", int'(dial_p1), 3);
    tick(1); check("cw_step1", int'(dial_p1), 2);
             check("cw_strobe_off", int'(step_pulse), 0);
    tick(8); check("cw_step2", int'(dial_p1), 0);
    tick(8); check("cw_step3", int'(dial_p1), 1);
    tick(8); check("cw_step4", int'(dial_p1), 3);
    tick(8); check("cw_step5", int'(dial_p1), 2);
    up = 2'b00;
    tick(6);
    check("cw_strobe_count", q1.size(), 5);
    for (int i = 0; i < 4; i++) check("cw_gap", gap1(i), 8);
    check("cw_phase_kept", int'(dial_p1), 2);

    // P1 counter-clockwise with acceleration through all levels
    q1.delete();
    down = 2'b01;
    tick(64);
    down = 2'b00;
    tick(5);
    check("acc_strobe_count", q1.size(), 20);
    for (int i = 0; i < 15; i++) check("acc_gap", gap1(i), exp_gap3[i]);
    check("acc_final_dial", int'(dial_p1), 2);

    // Pause in the middle of a period
    q1.delete();
    up = 2'b01;
    tick(3); check("pz_entry_dial", int'(dial_p1), 0);
    tick(2);
    paused = 1'b1;
    tick(20);
    check("pz_no_strobe", q1.size(), 1);
    check("pz_dial_held", int'(dial_p1), 0);
    check("pz_step_low", int'(step_pulse), 0);
    paused = 1'b0;
    tick(5); check("pz_resume_strobe", int'(step_pulse), 1);
    tick(1); check("pz_resume_dial", int'(dial_p1), 1);
    up = 2'b00;
    tick(4);
    check("pz_strobe_count", q1.size(), 2);
    check("pz_gap", gap1(0), 28);

    // P2 inverted direction, then reversal mid-run
    spin_en = 2'b11; dir_inv = 2'b10;
    tick(3);
    check("inv_en_dial", int'(dial_p2), 3);
    q2.delete();
    n1 = q1.size();
    up = 2'b10;
    tick(3); check("inv_step1", int'(dial_p2), 1);
    tick(8); check("inv_step2", int'(dial_p2), 0);
    tick(8); check("inv_step3", int'(dial_p2), 2);
    up = 2'b00; down = 2'b10;
    tick(2); check("rev_strobe", int'(step_pulse), 2);
    tick(1); check("rev_dial", int'(dial_p2), 0);
    tick(7); check("rev_next_strobe", int'(step_pulse), 2);
    down = 2'b00;
    tick(4);
    check("rev_strobe_count", q2.size(), 5);
    for (int i = 0; i < 4; i++) check("rev_gap", gap2(i), exp_gap5[i]);
    check("rev_p1_quiet", q1.size(), n1);
    check("rev_p1_dial", int'(dial_p1), 1);

    // Asynchronous reset while moving
    up = 2'b01;
    tick(11); check("ar_pre_dial", int'(dial_p1), 2);
    #2 reset_n = 1'b0;
    #1;
    check("ar_dial_p1", int'(dial_p1), 3);
    check("ar_dial_p2", int'(dial_p2), 3);
    check("ar_step", int'(step_pulse), 0);
    up = 2'b00;
    tick(2);
    reset_n = 1'b1;
    tick(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
